mem_sram_arbiter: RTL and testbench
===================================

Name: mem_sram_arbiter

Overview:
- Shares the single sram_axi_master command port between three requesters: port 0 is the ROM-to-RAM boot loader, port 1 is instruction fetch and port 2 is load/store.
- Grants one transaction at a time, latches its command and drives the master's en/wen/addr/size/din until done.
- Returns a done or error pulse plus read data to the winning requester.
- boot_lock restricts service to port 0 while the boot image is being copied.

Parameters:
- TIMEOUT, 256, max cycles in BUSY waiting for m_done before abort; minimum 2.
- CNT_W, 9, width of timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- boot_lock  in  1  1 = only port 0 eligible.
- req  in  3  per-port request; held with stable command until done_o/err_o of that port.
- wen_i  in  3  per-port write enable.
- addr_i  in  96  per-port byte address, port k at [32k+31:32k].
- size_i  in  6  per-port size, port k at [2k+1:2k]; 0 byte, 1 half, 2 word, 3 illegal.
- din_i  in  96  per-port write data.
- done_o  out  3  one-cycle completion pulse per port.
- err_o  out  3  one-cycle error pulse per port (illegal, misaligned or timeout).
- dout_o  out  32  read data, valid when done_o of a read port is high.
- stray_o  out  1  one-cycle pulse when m_done is seen outside BUSY.
- m_en, m_wen  out  1 each  to sram_axi_master.
- m_addr  out  32  to sram_axi_master.
- m_size  out  2  to sram_axi_master.
- m_din  out  32  to sram_axi_master.
- m_done  in  1  master completion pulse.
- m_dout  in  32  master read data, valid with m_done.

Behaviour:
- Reset: state IDLE. All outputs are 0. Round-robin last-winner pointer is 2, so port 0 has first priority. Timeout counter is 0.
- Reset asserted mid-transaction drops m_en immediately. A late m_done after reset only raises stray_o.
- All outputs are registered.
- States: IDLE, BUSY.
- Eligibility:
  - port k is eligible when req[k]=1 and done_o[k]=0 and err_o[k]=0 in the current cycle. This masks the one-cycle window before the requester drops req.
  - When boot_lock=1, only port 0 is eligible.
- Pick: round-robin, searching last+1, last+2, last (mod 3).
- IDLE, cycle T, winner k:
  - If size=3, or size=1 with addr[0]=1, or size=2 with addr[1:0]!=0: err_o[k]=1 at T+1, no master access, pointer updates, stay IDLE.
  - Otherwise, at T+1: m_en=1, the command is latched to m_*, the counter is cleared, pointer=k, state=BUSY.
- BUSY:
  - The m_* outputs stay constant and req/command changes are ignored.
  - m_done sampled high in cycle D: at D+1, done_o[k]=1, dout_o=m_dout (reads; dout_o is 0 for writes), m_en=0, state IDLE.
  - Earliest next m_en is D+2.
  - The counter increments each BUSY cycle without m_done. On reaching TIMEOUT-1: m_en=0, err_o[k]=1 next cycle, state IDLE. Deasserting m_en aborts the master's transaction.
  - m_done in the same cycle the counter reaches TIMEOUT-1 completes normally; done wins over timeout.
- m_done while IDLE: stray_o=1 next cycle, otherwise ignored.
- boot_lock rising while BUSY on port 1 or 2: the current transaction completes. Only then does port 0 get exclusivity.
- At most one bit of done_o|err_o is high in any cycle.
- Throughput: one transaction per (master latency + 2) cycles.
- Address is passed through unchanged, with no wrap or translation.

Decomposition:
- Shared package mem_pkg holds:
  - constants SIZE_B=0, SIZE_H=1, SIZE_W=2;
  - port indices P_BOOT=0, P_IF=1, P_LS=2;
  - state encoding.
- Sub-module mem_rr_pick is a combinational 3-way round-robin picker.
  - Inputs: eligible[2:0], last[1:0].
  - Outputs: valid, idx[1:0].

Test Plan:
- boot_lock=1; port 0 writes word 0xDEADBEEF to 0x100 while port 1 also requests. -> Only port 0 is granted: m_en with addr 0x100, size 2. Port 1 stays waiting. done_o[0] pulses the cycle after m_done.
- boot_lock=0; all three ports request continuously; master done latency 1. -> Grant order 0,1,2,0,1,2. m_en gap of exactly one cycle between transactions. No port is granted twice in succession.
- Port 2 half read at 0x203 (misaligned). -> err_o[2] one cycle after request, m_en never asserted. A byte read at 0x203 is then accepted.
- TIMEOUT=8, master never raises m_done. -> m_en high 7 cycles, then low. err_o[1]=1 for one cycle. A later m_done gives stray_o=1.
- Port 1 read at 0x40, m_dout=0x12345678 with m_done. -> dout_o=0x12345678 and done_o[1] in the same cycle. Held req in that cycle does not re-grant port 1.
- rst_n pulsed low while BUSY. -> m_en and all outputs are 0 asynchronously. After release, port 0 wins first.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants, state encoding and command legality check for the SRAM arbiter.
package mem_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [1:0] P_BOOT = 2'd0;
  localparam logic [1:0] P_IF   = 2'd1;
  localparam logic [1:0] P_LS   = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Size 3 is reserved; halves and words must be naturally aligned.
  function automatic logic cmd_illegal(input logic [1:0] size, input logic [1:0] alo);
    logic r;
    case (size)
      SIZE_B:  r = 1'b0;
      SIZE_H:  r = alo[0];
      SIZE_W:  r = (alo != 2'd0);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational 3-way round-robin picker; searches last+1, last+2, then last.
module mem_rr_pick import mem_pkg::*; (
  input  logic [2:0] eligible,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] w_c1;
  logic [1:0] w_c2;

  assign w_c1 = (last == P_LS) ? P_BOOT : last + 2'd1;
  assign w_c2 = (w_c1 == P_LS) ? P_BOOT : w_c1 + 2'd1;

  always_comb begin
    valid = |eligible;
    idx   = P_BOOT;
    if (eligible[w_c1])      idx = w_c1;
    else if (eligible[w_c2]) idx = w_c2;
    else if (eligible[last]) idx = last;
  end

endmodule

// File: rtl/mem_sram_arbiter.sv
// Arbitrates three requesters onto one sram_axi_master port, one transaction at a time,
// with alignment checking, a BUSY timeout and a boot-time lock to port 0.
module mem_sram_arbiter import mem_pkg::*; #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        boot_lock,
  input  logic [2:0]  req,
  input  logic [2:0]  wen_i,
  input  logic [95:0] addr_i,
  input  logic [5:0]  size_i,
  input  logic [95:0] din_i,
  output logic [2:0]  done_o,
  output logic [2:0]  err_o,
  output logic [31:0] dout_o,
  output logic        stray_o,
  output logic        m_en,
  output logic        m_wen,
  output logic [31:0] m_addr,
  output logic [1:0]  m_size,
  output logic [31:0] m_din,
  input  logic        m_done,
  input  logic [31:0] m_dout
);

  state_t           r_state;
  logic [1:0]       r_last;
  logic [1:0]       r_owner;
  logic [CNT_W-1:0] r_cnt;

  logic [2:0]  w_elig;
  logic        w_vld;
  logic [1:0]  w_idx;
  logic        w_wen;
  logic [31:0] w_addr;
  logic [1:0]  w_size;
  logic [31:0] w_din;
  logic [2:0]  w_owner_oh;

  // A port whose response is on the outputs this cycle still has req high; mask it.
  assign w_elig = req & ~done_o & ~err_o & (boot_lock ? 3'b001 : 3'b111);

  mem_rr_pick u_pick (
    .eligible (w_elig),
    .last     (r_last),
    .valid    (w_vld),
    .idx      (w_idx)
  );

  always_comb begin
    w_wen  = wen_i[0];
    w_addr = addr_i[31:0];
    w_size = size_i[1:0];
    w_din  = din_i[31:0];
    case (w_idx)
      P_IF: begin
        w_wen  = wen_i[1];
        w_addr = addr_i[63:32];
        w_size = size_i[3:2];
        w_din  = din_i[63:32];
      end
      P_LS: begin
        w_wen  = wen_i[2];
        w_addr = addr_i[95:64];
        w_size = size_i[5:4];
        w_din  = din_i[95:64];
      end
      default: ;
    endcase
  end

  assign w_owner_oh = 3'b001 << r_owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_last  <= P_LS;
      r_owner <= P_BOOT;
      r_cnt   <= '0;
      done_o  <= 3'b000;
      err_o   <= 3'b000;
      dout_o  <= 32'd0;
      stray_o <= 1'b0;
      m_en    <= 1'b0;
      m_wen   <= 1'b0;
      m_addr  <= 32'd0;
      m_size  <= 2'd0;
      m_din   <= 32'd0;
    end else begin
      done_o  <= 3'b000;
      err_o   <= 3'b000;
      dout_o  <= 32'd0;
      stray_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (m_done) stray_o <= 1'b1;
          if (w_vld) begin
            r_last <= w_idx;
            if (cmd_illegal(w_size, w_addr[1:0])) begin
              err_o <= 3'b001 << w_idx;
            end else begin
              m_en    <= 1'b1;
              m_wen   <= w_wen;
              m_addr  <= w_addr;
              m_size  <= w_size;
              m_din   <= w_din;
              r_owner <= w_idx;
              r_cnt   <= '0;
              r_state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          // Completion takes precedence over a timeout landing in the same cycle.
          if (m_done) begin
            done_o  <= w_owner_oh;
            if (!m_wen) dout_o <= m_dout;
            m_en    <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_cnt == CNT_W'(TIMEOUT - 2)) begin
            err_o   <= w_owner_oh;
            m_en    <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sram_arbiter.sv
// Directed scoreboard bench for mem_sram_arbiter with a behavioural SRAM master model.
module tb_mem_sram_arbiter;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        boot_lock = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [2:0]  wen_i = 3'b000;
  logic [95:0] addr_i = '0;
  logic [5:0]  size_i = '0;
  logic [95:0] din_i = '0;
  logic [2:0]  done_o, err_o;
  logic [31:0] dout_o;
  logic        stray_o;
  logic        m_en, m_wen;
  logic [31:0] m_addr, m_din;
  logic [1:0]  m_size;
  logic        m_done = 1'b0;
  logic [31:0] m_dout = 32'd0;

  always #5 clk = ~clk;

  mem_sram_arbiter #(.TIMEOUT(8), .CNT_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .boot_lock(boot_lock), .req(req), .wen_i(wen_i),
    .addr_i(addr_i), .size_i(size_i), .din_i(din_i), .done_o(done_o), .err_o(err_o),
    .dout_o(dout_o), .stray_o(stray_o), .m_en(m_en), .m_wen(m_wen), .m_addr(m_addr),
    .m_size(m_size), .m_din(m_din), .m_done(m_done), .m_dout(m_dout)
  );

  typedef struct {
    int          port;
    bit          is_err;
    logic [31:0] dout;
  } exp_t;

  exp_t sb[$];
  int   gaps[$];
  int   checks = 0, failures = 0, cyc = 0;
  int   mlat = 1, mcnt = 0, mdone_cyc = -10;
  logic [31:0] mdata = 32'h5A5A_0000;
  bit   kick = 0, hold = 0;
  logic [2:0] drop = 3'b000;
  int   en_hi = 0, stray_n = 0, fall_cyc = -1;
  logic prev_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int p, input bit e, input logic [31:0] d);
    exp_t x;
    x.port = p; x.is_err = e; x.dout = d;
    return x;
  endfunction

  // One clock: observe outputs at the falling edge, then drive the requester drops and master.
  task automatic step();
    exp_t e;
    int   p;
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      req  = req & ~drop;
      drop = 3'b000;
      if (m_en) en_hi++;
      if (m_en && !prev_en && fall_cyc >= 0) gaps.push_back(cyc - fall_cyc);
      if (!m_en && prev_en) fall_cyc = cyc;
      prev_en = m_en;
      if (stray_o) stray_n++;
      if ((done_o | err_o) != 3'b000) begin
        case (done_o | err_o)
          3'b001:  p = 0;
          3'b010:  p = 1;
          3'b100:  p = 2;
          default: p = -1;
        endcase
        if (sb.size() == 0) begin
          chk("unexpected_resp", {29'd0, done_o | err_o}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("resp_port", p, e.port);
          chk("resp_is_err", {31'd0, err_o != 3'b000}, {31'd0, e.is_err});
          if (!e.is_err) begin
            chk("resp_dout", dout_o, e.dout);
            chk("done_latency", cyc, mdone_cyc + 1);
          end
        end
        if (!hold) drop = done_o | err_o;
      end
    end
    m_done = 1'b0;
    if (kick) begin
      m_done = 1'b1;
      kick   = 0;
    end else if (m_en && rst_n) begin
      if (mlat >= 0 && mcnt == mlat) begin
        m_done    = 1'b1;
        m_dout    = mdata ^ m_addr;
        mdone_cyc = cyc;
      end
      mcnt++;
    end else begin
      mcnt = 0;
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) step();
    chk("drain", sb.size(), 0);
  endtask

  task automatic wait_en(input int budget);
    for (int i = 0; i < budget && !m_en; i++) step();
    chk("en_seen", {31'd0, m_en}, 32'd1);
  endtask

  task automatic set_cmd(input int k, input logic w, input logic [31:0] a,
                         input logic [1:0] s, input logic [31:0] d);
    wen_i[k]          = w;
    addr_i[32*k +: 32] = a;
    size_i[2*k +: 2]   = s;
    din_i[32*k +: 32]  = d;
    req[k]            = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 3'b000; drop = 3'b000; prev_en = 1'b0; fall_cyc = -1;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_m_en"}, {31'd0, m_en}, 32'd0);
    chk({tag, "_m_wen"}, {31'd0, m_wen}, 32'd0);
    chk({tag, "_m_addr"}, m_addr, 32'd0);
    chk({tag, "_m_din"}, m_din, 32'd0);
    chk({tag, "_resp"}, {26'd0, done_o, err_o}, 32'd0);
    chk({tag, "_dout"}, dout_o, 32'd0);
    chk({tag, "_stray"}, {31'd0, stray_o}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(); step();
    chk_idle_outputs("reset");
    rst_n = 1'b1;

    // Boot lock: only port 0 served while port 1 waits
    boot_lock = 1'b1;
    mlat = 1; en_hi = 0;
    set_cmd(0, 1'b1, 32'h100, SIZE_W, 32'hDEADBEEF);
    set_cmd(1, 1'b0, 32'h40, SIZE_W, 32'd0);
    sb.push_back(mk(0, 0, 32'd0));
    wait_en(10);
    chk("boot_addr", m_addr, 32'h100);
    chk("boot_size", {30'd0, m_size}, {30'd0, SIZE_W});
    chk("boot_wen", {31'd0, m_wen}, 32'd1);
    chk("boot_din", m_din, 32'hDEADBEEF);
    drain(20);
    repeat (4) step();
    chk("boot_only_p0", en_hi, 2);
    boot_lock = 1'b0;
    sb.push_back(mk(1, 0, mdata ^ 32'h40));
    drain(20);

    // Continuous requests from all ports: fair rotation starting at port 0
    do_reset();
    hold = 1; gaps.delete();
    set_cmd(0, 1'b1, 32'h0, SIZE_W, 32'h11);
    set_cmd(1, 1'b0, 32'h4, SIZE_W, 32'd0);
    set_cmd(2, 1'b0, 32'h9, SIZE_B, 32'd0);
    for (int r = 0; r < 2; r++) begin
      sb.push_back(mk(0, 0, 32'd0));
      sb.push_back(mk(1, 0, mdata ^ 32'h4));
      sb.push_back(mk(2, 0, mdata ^ 32'h9));
    end
    drain(100);
    req = 3'b000; hold = 0;
    chk("rr_gap_count", gaps.size(), 5);
    foreach (gaps[i]) chk("rr_gap", gaps[i], 1);

    // Misaligned half read is rejected without touching the master
    repeat (2) step();
    en_hi = 0;
    set_cmd(2, 1'b0, 32'h203, SIZE_H, 32'd0);
    sb.push_back(mk(2, 1, 32'd0));
    step();
    chk("misalign_err_latency", sb.size(), 0);
    repeat (3) step();
    chk("misalign_no_access", en_hi, 0);
    set_cmd(2, 1'b0, 32'h203, SIZE_B, 32'd0);
    sb.push_back(mk(2, 0, mdata ^ 32'h203));
    drain(20);

    // Timeout with a silent master, then a late m_done is stray
    repeat (2) step();
    mlat = -1; en_hi = 0;
    set_cmd(1, 1'b0, 32'h80, SIZE_W, 32'd0);
    sb.push_back(mk(1, 1, 32'd0));
    drain(40);
    repeat (2) step();
    chk("timeout_en_cycles", en_hi, 7);
    stray_n = 0; kick = 1;
    step(); step();
    chk("timeout_stray", stray_n, 1);

    // Read data returned with done; held req is not re-granted
    mlat = 0; mdata = 32'h12345678 ^ 32'h40;
    set_cmd(1, 1'b0, 32'h40, SIZE_W, 32'd0);
    sb.push_back(mk(1, 0, 32'h12345678));
    drain(20);
    en_hi = 0;
    repeat (3) step();
    chk("no_regrant", en_hi, 0);

    // Asynchronous reset mid-transaction
    mlat = -1;
    set_cmd(2, 1'b1, 32'h300, SIZE_W, 32'hCAFE);
    wait_en(10);
    step(); step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    req = 3'b000; drop = 3'b000; sb.delete(); prev_en = 1'b0; fall_cyc = -1;
    step(); step();
    rst_n = 1'b1;
    stray_n = 0; kick = 1;
    step(); step();
    chk("late_done_stray", stray_n, 1);
    chk("late_done_no_resp", sb.size(), 0);
    mlat = 1; mdata = 32'h0F0F_0000;
    set_cmd(0, 1'b0, 32'h10, SIZE_W, 32'd0);
    set_cmd(1, 1'b0, 32'h14, SIZE_H, 32'd0);
    set_cmd(2, 1'b1, 32'h18, SIZE_B, 32'h77);
    sb.push_back(mk(0, 0, mdata ^ 32'h10));
    sb.push_back(mk(1, 0, mdata ^ 32'h14));
    sb.push_back(mk(2, 0, 32'd0));
    drain(60);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
